// File: rtl/pgm_sched.sv
// Packet generator scheduler: replays a flit sequence from packet RAM as packets,
// with inter-packet gap, downstream almost-full pacing and a boundary-aligned stop.
module pgm_sched #(
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic [ADDR_W-1:0] cfg_start_addr,
   input  logic [ADDR_W-1:0] cfg_pkt_len,
   input  logic [CNT_W-1:0]  cfg_pkt_num,
   input  logic [CNT_W-1:0]  cfg_gap,
   input  logic              start,
   input  logic              stop,
   output logic              ram_rd,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [143:0]      ram_rdata,
   output logic [133:0]      out_data,
   output logic              out_data_wr,
   output logic              out_valid,
   output logic              out_valid_wr,
   input  logic              in_alf,
   output logic              busy,
   output logic              sent_start_flag,
   output logic              sent_finish_flag,
   output logic [CNT_W-1:0]  sent_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_GAP, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
   logic [ADDR_W-1:0]  pkt_len_q, pkt_len_d;
   logic [CNT_W-1:0]   pkt_num_q, pkt_num_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  flit_q, flit_d;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [CNT_W-1:0]   sent_cnt_q, sent_cnt_d;
   logic               stop_lat_q, stop_lat_d;
   logic               first_q, first_d;
   logic               rd_q, rd_d;
   logic               data_wr_q, data_wr_d;
   logic               valid_wr_q, valid_wr_d;
   logic               sflag_q, sflag_d;
   logic               fflag_q, fflag_d;
   logic               busy_q, busy_d;
   logic               gap_done;
   logic               unused_rdata;

   assign unused_rdata = ^ram_rdata[143:134];
   assign gap_done     = (gap_q == '0) || (gap_cnt_q == gap_q - 1'b1);

   always_comb begin
      state_d      = state_q;
      start_addr_d = start_addr_q;
      pkt_len_d    = pkt_len_q;
      pkt_num_d    = pkt_num_q;
      gap_d        = gap_q;
      addr_d       = addr_q;
      flit_d       = flit_q;
      gap_cnt_d    = gap_cnt_q;
      issued_d     = issued_q;
      sent_cnt_d   = sent_cnt_q;
      stop_lat_d   = stop_lat_q;
      first_d      = first_q;
      rd_d         = 1'b0;
      data_wr_d    = rd_q;
      valid_wr_d   = 1'b0;
      sflag_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_wr) begin
               start_addr_d = cfg_start_addr;
               pkt_len_d    = cfg_pkt_len;
               pkt_num_d    = cfg_pkt_num;
               gap_d        = cfg_gap;
            end
            if (start && !stop && pkt_len_q != '0) begin
               state_d    = S_WAIT;
               sent_cnt_d = '0;
               issued_d   = '0;
               first_d    = 1'b1;
               stop_lat_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (stop_lat_q || stop) begin
               state_d = S_DONE;
            end else if (!in_alf) begin
               state_d = S_READ;
               rd_d    = 1'b1;
               addr_d  = start_addr_q;
               flit_d  = '0;
               sflag_d = first_q;
               first_d = 1'b0;
            end
         end
         S_READ: begin
            if (stop) stop_lat_d = 1'b1;
            // flit_q indexes the read presented this cycle; the last one tags the tail
            if (flit_q == pkt_len_q - 1'b1) begin
               state_d    = S_GAP;
               gap_cnt_d  = '0;
               issued_d   = issued_q + 1'b1;
               valid_wr_d = 1'b1;
               if (sent_cnt_q != '1) sent_cnt_d = sent_cnt_q + 1'b1;
            end else begin
               rd_d   = 1'b1;
               flit_d = flit_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         S_GAP: begin
            if (stop) stop_lat_d = 1'b1;
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_done) begin
               if (stop_lat_q || stop || (pkt_num_q != '0 && issued_q == pkt_num_q))
                  state_d = S_DONE;
               else
                  state_d = S_WAIT;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            stop_lat_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      fflag_d = (state_d == S_DONE) && (state_q != S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         start_addr_q <= '0;
         pkt_len_q    <= '0;
         pkt_num_q    <= '0;
         gap_q        <= '0;
         addr_q       <= '0;
         flit_q       <= '0;
         gap_cnt_q    <= '0;
         issued_q     <= '0;
         sent_cnt_q   <= '0;
         stop_lat_q   <= 1'b0;
         first_q      <= 1'b0;
         rd_q         <= 1'b0;
         data_wr_q    <= 1'b0;
         valid_wr_q   <= 1'b0;
         sflag_q      <= 1'b0;
         fflag_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_addr_q <= start_addr_d;
         pkt_len_q    <= pkt_len_d;
         pkt_num_q    <= pkt_num_d;
         gap_q        <= gap_d;
         addr_q       <= addr_d;
         flit_q       <= flit_d;
         gap_cnt_q    <= gap_cnt_d;
         issued_q     <= issued_d;
         sent_cnt_q   <= sent_cnt_d;
         stop_lat_q   <= stop_lat_d;
         first_q      <= first_d;
         rd_q         <= rd_d;
         data_wr_q    <= data_wr_d;
         valid_wr_q   <= valid_wr_d;
         sflag_q      <= sflag_d;
         fflag_q      <= fflag_d;
         busy_q       <= busy_d;
      end
   end

   // RAM data arrives one cycle after the read, so the flit passes straight through
   assign out_data         = data_wr_q ? ram_rdata[133:0] : '0;
   assign out_data_wr      = data_wr_q;
   assign out_valid        = valid_wr_q;
   assign out_valid_wr     = valid_wr_q;
   assign ram_rd           = rd_q;
   assign ram_addr         = addr_q;
   assign busy             = busy_q;
   assign sent_start_flag  = sflag_q;
   assign sent_finish_flag = fflag_q;
   assign sent_cnt         = sent_cnt_q;

endmodule

// File: tb/tb_pgm_sched.sv
// Directed bench for pgm_sched: RAM model, negedge event recorder, hand-computed expectations.
module tb_pgm_sched;

   logic         clk = 1'b0;
   logic         rst, cfg_wr, start, stop, in_alf;
   logic [6:0]   cfg_start_addr, cfg_pkt_len;
   logic [15:0]  cfg_pkt_num, cfg_gap;
   logic         ram_rd, out_data_wr, out_valid, out_valid_wr, busy;
   logic         sent_start_flag, sent_finish_flag;
   logic [6:0]   ram_addr;
   logic [143:0] ram_rdata = '0;
   logic [133:0] out_data;
   logic [15:0]  sent_cnt;

   int checks = 0, errors = 0, cyc = 0;
   int rd_addr[$], rd_cyc[$], wr_cyc[$];
   logic [133:0] wr_dat[$];
   int vwr_n, vbad_n, sflag_n, sflag_cyc, fflag_n, fflag_cyc;

   pgm_sched dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_start_addr(cfg_start_addr),
      .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap),
      .start(start), .stop(stop), .ram_rd(ram_rd), .ram_addr(ram_addr),
      .ram_rdata(ram_rdata), .out_data(out_data), .out_data_wr(out_data_wr),
      .out_valid(out_valid), .out_valid_wr(out_valid_wr), .in_alf(in_alf),
      .busy(busy), .sent_start_flag(sent_start_flag),
      .sent_finish_flag(sent_finish_flag), .sent_cnt(sent_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [133:0] exp_dat(input int a);
      logic [6:0] a7;
      a7 = a[6:0];
      return {120'h0, a7 ^ 7'h2A, a7};
   endfunction

   always @(posedge clk)
      ram_rdata <= ram_rd ? {10'h155, 120'h0, ram_addr ^ 7'h2A, ram_addr} : '0;

   always @(negedge clk) begin
      if (ram_rd) begin rd_addr.push_back(int'(ram_addr)); rd_cyc.push_back(cyc); end
      if (out_data_wr) begin wr_cyc.push_back(cyc); wr_dat.push_back(out_data); end
      if (out_valid_wr) begin vwr_n++; if (!out_valid) vbad_n++; end
      if (sent_start_flag) begin sflag_n++; sflag_cyc = cyc; end
      if (sent_finish_flag) begin fflag_n++; fflag_cyc = cyc; end
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic mon_clr();
      rd_addr.delete(); rd_cyc.delete(); wr_cyc.delete(); wr_dat.delete();
      vwr_n = 0; vbad_n = 0; sflag_n = 0; sflag_cyc = -1; fflag_n = 0; fflag_cyc = -1;
   endtask

   task automatic cfg(input int a, input int l, input int n, input int g);
      cfg_start_addr = 7'(a); cfg_pkt_len = 7'(l); cfg_pkt_num = 16'(n); cfg_gap = 16'(g);
      cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
   endtask

   task automatic pulse_start(output int t);
      t = cyc; start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 500) begin tick(); n++; end
      chk(tag, busy, 1'b0);
      tick(2);
   endtask

   function automatic logic [29:0] outs();
      return {ram_rd, ram_addr, out_data_wr, out_valid, out_valid_wr, busy,
              sent_start_flag, sent_finish_flag, sent_cnt};
   endfunction

   initial begin
      int t, n, w;
      rst = 1'b1; cfg_wr = 0; start = 0; stop = 0; in_alf = 0;
      cfg_start_addr = 0; cfg_pkt_len = 0; cfg_pkt_num = 0; cfg_gap = 0;
      mon_clr();
      tick(2);
      chk("rst_outs", outs(), '0);
      chk("rst_data", out_data, '0);
      rst = 1'b0; tick();

      // basic two-packet run with exact cycle timing
      mon_clr();
      cfg(5, 3, 2, 2);
      pulse_start(t);
      wait_idle("t1_idle");
      chk("t1_rd_n", rd_addr.size(), 6);
      chk("t1_addr", {rd_addr[0][6:0], rd_addr[1][6:0], rd_addr[2][6:0]}, {7'd5, 7'd6, 7'd7});
      chk("t1_rdcyc", {rd_cyc[0] - t, rd_cyc[2] - t, rd_cyc[3] - t}, {32'd2, 32'd4, 32'd8});
      chk("t1_wrcyc", {wr_cyc[0] - t, wr_cyc[2] - t}, {32'd3, 32'd5});
      chk("t1_data0", wr_dat[0], exp_dat(5));
      chk("t1_data2", wr_dat[2], exp_dat(7));
      chk("t1_vwr", {vwr_n, vbad_n}, {32'd2, 32'd0});
      chk("t1_sent", sent_cnt, 16'd2);
      chk("t1_sflag", {sflag_n, sflag_cyc - t}, {32'd1, 32'd2});
      chk("t1_fflag", {fflag_n, fflag_cyc - t}, {32'd1, 32'd13});

      // address wrap
      mon_clr();
      cfg(126, 4, 1, 0);
      pulse_start(t);
      wait_idle("t2_idle");
      chk("t2_rd_n", rd_addr.size(), 4);
      chk("t2_addr", {rd_addr[0][6:0], rd_addr[1][6:0], rd_addr[2][6:0], rd_addr[3][6:0]},
          {7'd126, 7'd127, 7'd0, 7'd1});
      chk("t2_data3", wr_dat[3], exp_dat(1));

      // almost-full holds off the packet; mid-packet almost-full is ignored
      mon_clr();
      cfg(20, 6, 1, 0);
      in_alf = 1'b1;
      pulse_start(t);
      tick(10);
      chk("t3_hold", {rd_addr.size(), 31'd0, busy}, {32'd0, 31'd0, 1'b1});
      in_alf = 1'b0;
      n = 0;
      while (rd_addr.size() < 2 && n < 50) begin tick(); n++; end
      in_alf = 1'b1;
      wait_idle("t3_idle");
      in_alf = 1'b0;
      chk("t3_rd_n", {rd_addr.size(), wr_cyc.size(), vwr_n}, {32'd6, 32'd6, 32'd1});

      // free-running with stop during the second packet
      mon_clr();
      cfg(40, 3, 0, 1);
      pulse_start(t);
      n = 0;
      while (rd_addr.size() < 4 && n < 100) begin tick(); n++; end
      stop = 1'b1; tick(); stop = 1'b0;
      wait_idle("t4_idle");
      chk("t4_pkts", {rd_addr.size(), vwr_n, 16'(sent_cnt)}, {32'd6, 32'd2, 16'd2});
      chk("t4_fflag", fflag_n, 1);

      // illegal length and start+stop collision stay idle
      mon_clr();
      cfg(3, 0, 1, 0);
      pulse_start(t);
      tick(3);
      chk("t5_len0", {busy, rd_addr.size(), sflag_n, fflag_n}, {1'b0, 96'd0});
      cfg(3, 2, 1, 0);
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      tick(3);
      chk("t5_ss", {busy, rd_addr.size(), sflag_n, fflag_n}, {1'b0, 96'd0});

      // reset on the second flit aborts; a fresh run then restarts cleanly
      mon_clr();
      cfg(10, 4, 1, 0);
      pulse_start(t);
      n = 0;
      while (wr_cyc.size() < 1 && n < 50) begin tick(); n++; end
      rst = 1'b1; tick(); 
      chk("t6_rst_outs", outs(), '0);
      chk("t6_rst_data", out_data, '0);
      rst = 1'b0;
      w = wr_cyc.size();
      tick(5);
      chk("t6_quiet", {wr_cyc.size(), fflag_n, 31'd0, busy}, {w, 32'd0, 32'd0});
      mon_clr();
      cfg(10, 4, 1, 0);
      pulse_start(t);
      wait_idle("t6_idle");
      chk("t6_rerun", {rd_addr.size(), rd_addr[0], vwr_n, fflag_n}, {32'd4, 32'd10, 32'd1, 32'd1});
      chk("t6_data0", wr_dat[0], exp_dat(10));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pgm_sched.md
PGM_SCHED -- requirements
Module: pgm_sched

Interface
REQ-001 Parameter: ADDR_W, 7, packet RAM address width (128-entry RAM).
REQ-002 Parameter: CNT_W, 16, width of packet-count, gap and sent-count fields.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: cfg_wr  in  1  one-cycle strobe; latches the cfg_* fields.
REQ-006 Port: cfg_start_addr  in  ADDR_W  RAM address of the first flit.
REQ-007 Port: cfg_pkt_len  in  ADDR_W  flits per packet, 1..127; 0 is illegal.
REQ-008 Port: cfg_pkt_num  in  CNT_W  packets to generate; 0 = run until stop.
REQ-009 Port: cfg_gap  in  CNT_W  idle cycles after each packet.
REQ-010 Port: start  in  1  one-cycle pulse that begins generation.
REQ-011 Port: stop  in  1  one-cycle pulse that ends generation at the next packet boundary.
REQ-012 Port: ram_rd  out  1  RAM read enable.
REQ-013 Port: ram_addr  out  ADDR_W  RAM read address.
REQ-014 Port: ram_rdata  in  144  RAM read data, 1-cycle latency; bits [133:0] carry the flit.
REQ-015 Port: out_data  out  134  generated flit.
REQ-016 Port: out_data_wr  out  1  out_data valid strobe.
REQ-017 Port: out_valid  out  1  packet-valid flag, 1 = good packet.
REQ-018 Port: out_valid_wr  out  1  strobe for out_valid, asserted on the tail flit.
REQ-019 Port: in_alf  in  1  downstream almost-full.
REQ-020 Port: busy  out  1  high in any state other than IDLE.
REQ-021 Port: sent_start_flag  out  1  one-cycle pulse when generation starts.
REQ-022 Port: sent_finish_flag  out  1  one-cycle pulse when generation completes.
REQ-023 Port: sent_cnt  out  CNT_W  packets fully emitted since the last start.

Function
REQ-024 States SHALL be IDLE, WAIT, READ, GAP, DONE.
REQ-025 cfg_wr SHALL load the shadow config only in IDLE; it SHALL be ignored otherwise.
REQ-026 IDLE->WAIT on start only if shadow cfg_pkt_len!=0 and stop=0; in that cycle sent_cnt clears to 0.
REQ-027 start or cfg_wr while busy SHALL be ignored.
REQ-028 If start and stop coincide in IDLE, the FSM SHALL remain in IDLE with no flags.
REQ-029 WAIT: in_alf is sampled each cycle; in_alf=0 -> READ, address counter loads cfg_start_addr, flit counter clears.
REQ-030 Stop sampled in WAIT SHALL take the FSM to DONE without reading.
REQ-031 READ: ram_rd=1 every cycle for exactly cfg_pkt_len cycles.
REQ-032 READ: ram_addr increments by 1 per flit and wraps 127->0.
REQ-033 in_alf SHALL be ignored in READ; it is checked only at packet boundaries.
REQ-034 out_data=ram_rdata[133:0] with out_data_wr=1 exactly one cycle after each ram_rd.
REQ-035 On the last flit's output cycle: out_valid_wr=1, out_valid=1, sent_cnt +1 (saturating at all-ones).
REQ-036 After the last read, READ->GAP with gap counter =0.
REQ-037 GAP: counts cfg_gap cycles; cfg_gap=0 SHALL spend exactly 1 cycle in GAP.
REQ-038 GAP exit -> DONE if the stop latch is set, or if cfg_pkt_num!=0 and packets issued==cfg_pkt_num; else -> WAIT.
REQ-039 A stop pulse in READ/GAP/WAIT SHALL set a stop latch and never truncate a packet in flight.
REQ-040 sent_start_flag SHALL pulse coincident with the first ram_rd after start, once per run.
REQ-041 DONE SHALL last 1 cycle, pulse sent_finish_flag, clear the stop latch, then return to IDLE.
REQ-042 Packet-issue counter SHALL be CNT_W wide; with cfg_pkt_num=0 it SHALL not terminate generation.

Reset
REQ-043 With rst=1 at a clock edge, next cycle: state IDLE, shadow config 0, and every output 0 (ram_rd, ram_addr, out_data, out_data_wr, out_valid, out_valid_wr, busy, both flags, sent_cnt).
REQ-044 Reset mid-packet SHALL abort immediately: no further out_data_wr, and no sent_finish_flag.

Verification
REQ-045 Config addr=5, len=3, num=2, gap=2, in_alf=0, start at cycle T -> ram_addr 5,6,7 at T+2..T+4; out_data_wr T+3..T+5; 2 packets; sent_cnt=2; one sent_finish_flag pulse.
REQ-046 Config addr=126, len=4 -> ram_addr sequence 126,127,0,1.
REQ-047 in_alf=1 held 10 cycles after start -> no ram_rd until in_alf falls; asserting in_alf mid-packet does not stall the packet.
REQ-048 num=0, stop pulsed during the 2nd packet's READ -> 2nd packet completes with out_valid_wr; sent_cnt=2; then DONE and IDLE.
REQ-049 cfg_wr len=0 then start -> remains IDLE, busy=0, no flags; start and stop in the same cycle -> remains IDLE.
REQ-050 rst asserted on the 2nd flit -> all outputs 0 next cycle; a new start then runs normally from cfg_start_addr.
